accum_processor_core: RTL and testbench

16-bit multicycle accumulator processor core with an external instruction/data memory interface.
- A single accumulator register (CR) is the implicit operand of every operation.
- A 16-entry register file holds spill values.
- Each instruction runs through Fetch, Decode, then 1–3 execute states.
- Memory lives outside the block: the block drives the address (IorDOutput) and samples Instruction and MemDataOut.

---
 rtl/accum_processor_core.sv | 169 ++++++++++++++++
 tb/tb_accum_processor_core.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_processor_core.sv
// 16-bit multicycle accumulator processor core with external instruction/data memory.
// Optional build macro IO_INPUT_EN enables the "in" instruction (op 00100).
module accum_processor_core #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] Instruction,
    input  logic [15:0] MemDataOut,
    input  logic [15:0] Input,
    output logic [15:0] IorDOutput
);

    localparam int unsigned W     = 16;
    localparam int unsigned IMM_W = 11;
    localparam int unsigned IDX_W = 4;

    localparam logic [4:0] OP_MOV   = 5'b00000;
    localparam logic [4:0] OP_SET   = 5'b00001;
    localparam logic [4:0] OP_SETC  = 5'b00010;
    localparam logic [4:0] OP_LD    = 5'b00011;
    localparam logic [4:0] OP_IN    = 5'b00100;
    localparam logic [4:0] OP_SETPC = 5'b00101;
    localparam logic [4:0] OP_SUB   = 5'b01001;
    localparam logic [4:0] OP_ADD   = 5'b01010;
    localparam logic [4:0] OP_ADDI  = 5'b01011;
    localparam logic [4:0] OP_AND   = 5'b01100;
    localparam logic [4:0] OP_OR    = 5'b01101;
    localparam logic [4:0] OP_SRL   = 5'b01110;
    localparam logic [4:0] OP_SLL   = 5'b01111;
    localparam logic [4:0] OP_JUMP  = 5'b10000;
    localparam logic [4:0] OP_BEQ   = 5'b11000;
    localparam logic [4:0] OP_BNE   = 5'b11100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MOV, S_SET, S_SETC, S_WRREG, S_ADDR, S_MEMRD,
        S_WRCR, S_IN, S_CROP, S_JUMP, S_BRANCH, S_BEQ, S_BNE, S_BTAKEN
    } state_t;

    state_t         state;
    logic [W-1:0]   pc, cr, ir, mdr, alu_out;
    logic [W-1:0]   regs [NUM_REGS];

    logic [4:0]       op;
    logic [IMM_W-1:0] imm;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     sext_imm, reg_rd, alu_res;

    assign op       = ir[15:11];
    assign imm      = ir[IMM_W-1:0];
    assign idx      = ir[IDX_W-1:0];
    assign sext_imm = {{(W-IMM_W){imm[IMM_W-1]}}, imm};
    assign reg_rd   = (idx == '0) ? '0 : regs[idx];

    // The address mux only selects ALUOut during the data read.
    assign IorDOutput = (state == S_MEMRD) ? alu_out : pc;

`ifndef IO_INPUT_EN
    logic unused_input;
    assign unused_input = ^Input;
`endif

    // Result computed in CROP for setpc and the ALU ops.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_SETPC: alu_res = pc + sext_imm;
            OP_SUB:   alu_res = cr - reg_rd;
            OP_ADD:   alu_res = cr + reg_rd;
            OP_ADDI:  alu_res = cr + sext_imm;
            OP_AND:   alu_res = cr & reg_rd;
            OP_OR:    alu_res = cr | reg_rd;
            OP_SRL:   alu_res = cr >> imm[3:0];
            OP_SLL:   alu_res = cr << imm[3:0];
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            cr      <= '0;
            ir      <= '0;
            mdr     <= '0;
            alu_out <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= Instruction;
                    pc    <= pc + W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_MOV:   state <= S_MOV;
                        OP_SET:   state <= S_SET;
                        OP_SETC:  state <= S_SETC;
                        OP_LD:    state <= S_ADDR;
`ifdef IO_INPUT_EN
                        OP_IN:    state <= S_IN;
`endif
                        OP_SETPC, OP_SUB, OP_ADD, OP_ADDI,
                        OP_AND, OP_OR, OP_SRL, OP_SLL:
                                  state <= S_CROP;
                        OP_JUMP:  state <= S_JUMP;
                        OP_BEQ, OP_BNE:
                                  state <= S_BRANCH;
                        default:  state <= S_FETCH;
                    endcase
                end
                S_MOV: begin
                    cr    <= W'(imm);
                    state <= S_FETCH;
                end
                S_SET: begin
                    alu_out <= reg_rd;
                    state   <= S_WRCR;
                end
                S_SETC:  state <= S_WRREG;
                S_WRREG: begin
                    if (idx != '0) regs[idx] <= cr;
                    state <= S_FETCH;
                end
                S_ADDR: begin
                    alu_out <= cr + sext_imm;
                    state   <= S_MEMRD;
                end
                S_MEMRD: begin
                    mdr   <= MemDataOut;
                    state <= S_WRCR;
                end
                S_WRCR: begin
                    cr    <= (op == OP_LD) ? mdr : alu_out;
                    state <= S_FETCH;
                end
`ifdef IO_INPUT_EN
                S_IN: begin
                    cr    <= Input;
                    state <= S_FETCH;
                end
`endif
                S_CROP: begin
                    alu_out <= alu_res;
                    state   <= S_WRCR;
                end
                S_JUMP: begin
                    pc    <= {pc[W-1:IMM_W], imm};
                    state <= S_FETCH;
                end
                // PC has already been incremented in FETCH.
                S_BRANCH: begin
                    alu_out <= pc + sext_imm;
                    state   <= (op == OP_BEQ) ? S_BEQ : S_BNE;
                end
                S_BEQ:    state <= (cr == '0) ? S_BTAKEN : S_FETCH;
                S_BNE:    state <= (cr != '0) ? S_BTAKEN : S_FETCH;
                S_BTAKEN: begin
                    pc    <= alu_out;
                    state <= S_FETCH;
                end
                default:  state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_processor_core.sv
// Self-checking bench for accum_processor_core; expected CR/PC per instruction go through a scoreboard queue.
module tb_accum_processor_core;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] Instruction;
    logic [15:0] MemDataOut;
    logic [15:0] Input;
    logic [15:0] IorDOutput;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] cr;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];

    accum_processor_core dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Instruction(Instruction),
        .MemDataOut (MemDataOut),
        .Input      (Input),
        .IorDOutput (IorDOutput)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] imm);
        return {op, imm};
    endfunction

    // Queue the expected architectural state, then hold the instruction for its cycle count.
    task automatic issue(input string nm, input logic [15:0] ins, input int cyc,
                         input logic [15:0] ecr, input logic [15:0] epc);
        exp_t e;
        e.name = nm; e.cr = ecr; e.pc = epc;
        sb.push_back(e);
        Instruction = ins;
        repeat (cyc) @(negedge CLK);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Instruction = enc(5'b01011, 11'd15);
        @(negedge CLK);
        Reset = 1'b0;
        checks++;
        if (dut.cr !== 16'h0000) begin
            failures++; $display("FAIL reset_cr actual=%h required=%h", dut.cr, 16'h0000);
        end
        checks++;
        if (IorDOutput !== 16'h0000) begin
            failures++; $display("FAIL reset_addr actual=%h required=%h", IorDOutput, 16'h0000);
        end
        checks++;
        if (dut.regs[7] !== 16'h0000) begin
            failures++; $display("FAIL reset_r7 actual=%h required=%h", dut.regs[7], 16'h0000);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: issue("addi15", enc(5'b01011, 11'd15), 4, 16'd15, 16'd1);
                1: issue("setc7",  enc(5'b00010, 11'd7),  4, 16'd15, 16'd2);
                2: issue("addi5",  enc(5'b01011, 11'd5),  4, 16'd20, 16'd3);
                3: issue("mov2",   enc(5'b00000, 11'd2),  3, 16'd2,  16'd4);
                4: issue("set7",   enc(5'b00001, 11'd7),  4, 16'd15, 16'd5);
                5: issue("add7",   enc(5'b01010, 11'd7),  4, 16'd30, 16'd6);
                6: issue("sub7",   enc(5'b01001, 11'd7),  4, 16'd15, 16'd7);
                default: issue("sll2", enc(5'b01111, 11'd2), 4, 16'd60, 16'd8);
            endcase
            e = sb.pop_front();
            checks++;
            if (dut.cr !== e.cr) begin
                failures++; $display("FAIL %s_cr actual=%h required=%h", e.name, dut.cr, e.cr);
            end
            checks++;
            if (IorDOutput !== e.pc) begin
                failures++; $display("FAIL %s_pc actual=%h required=%h", e.name, IorDOutput, e.pc);
            end
            if (i == 1) begin
                checks++;
                if (dut.regs[7] !== 16'd15) begin
                    failures++; $display("FAIL setc7_r7 actual=%h required=%h", dut.regs[7], 16'd15);
                end
            end
        end
    endtask

    task automatic test_jump();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) issue("setpc2", enc(5'b00101, 11'd2), 4, 16'd11, 16'd9);
            else        issue("jump32", enc(5'b10000, 11'd32), 3, 16'd11, 16'd32);
            e = sb.pop_front();
            checks++;
            if (dut.cr !== e.cr) begin
                failures++; $display("FAIL %s_cr actual=%h required=%h", e.name, dut.cr, e.cr);
            end
            checks++;
            if (IorDOutput !== e.pc) begin
                failures++; $display("FAIL %s_pc actual=%h required=%h", e.name, IorDOutput, e.pc);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: issue("beq_nt",  enc(5'b11000, 11'd64),  4, 16'd11, 16'd33);
                1: issue("bne_t",   enc(5'b11100, 11'd128), 5, 16'd11, 16'd162);
                2: issue("set0",    enc(5'b00001, 11'd0),   4, 16'd0,  16'd163);
                3: issue("setc0",   enc(5'b00010, 11'd0),   4, 16'd0,  16'd164);
                default: issue("set0b", enc(5'b00001, 11'd0), 4, 16'd0, 16'd165);
            endcase
            e = sb.pop_front();
            checks++;
            if (dut.cr !== e.cr) begin
                failures++; $display("FAIL %s_cr actual=%h required=%h", e.name, dut.cr, e.cr);
            end
            checks++;
            if (IorDOutput !== e.pc) begin
                failures++; $display("FAIL %s_pc actual=%h required=%h", e.name, IorDOutput, e.pc);
            end
        end
        checks++;
        if (dut.regs[0] !== 16'h0000) begin
            failures++; $display("FAIL r0_zero actual=%h required=%h", dut.regs[0], 16'h0000);
        end
    endtask

    // Immediate extension, wrap, shifts, logic ops and an undefined opcode.
    task automatic test_alu_bounds();
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0:  issue("mov7ff",   enc(5'b00000, 11'h7FF), 3, 16'h07FF, 16'd166);
                1:  issue("addim1",   enc(5'b01011, 11'h7FF), 4, 16'h07FE, 16'd167);
                2:  issue("srl4",     enc(5'b01110, 11'd4),   4, 16'h007F, 16'd168);
                3:  issue("setc3",    enc(5'b00010, 11'd3),   4, 16'h007F, 16'd169);
                4:  issue("mov0f0",   enc(5'b00000, 11'h0F0), 3, 16'h00F0, 16'd170);
                5:  issue("or3",      enc(5'b01101, 11'd3),   4, 16'h00FF, 16'd171);
                6:  issue("and3",     enc(5'b01100, 11'd3),   4, 16'h007F, 16'd172);
                7:  issue("sub3",     enc(5'b01001, 11'd3),   4, 16'h0000, 16'd173);
                8:  issue("sub3wrap", enc(5'b01001, 11'd3),   4, 16'hFF81, 16'd174);
                9:  issue("nop",      enc(5'b11111, 11'h555), 2, 16'hFF81, 16'd175);
                default: issue("sll15", enc(5'b01111, 11'd15), 4, 16'h8000, 16'd176);
            endcase
            e = sb.pop_front();
            checks++;
            if (dut.cr !== e.cr) begin
                failures++; $display("FAIL %s_cr actual=%h required=%h", e.name, dut.cr, e.cr);
            end
            checks++;
            if (IorDOutput !== e.pc) begin
                failures++; $display("FAIL %s_pc actual=%h required=%h", e.name, IorDOutput, e.pc);
            end
        end
    endtask

    task automatic test_load_and_reset();
        exp_t e;
        issue("mov16", enc(5'b00000, 11'd16), 3, 16'd16, 16'd177);
        e = sb.pop_front();
        checks++;
        if (dut.cr !== e.cr) begin
            failures++; $display("FAIL %s_cr actual=%h required=%h", e.name, dut.cr, e.cr);
        end
        Instruction = enc(5'b00011, 11'd4);
        MemDataOut  = 16'h0000;
        repeat (3) @(negedge CLK);
        checks++;
        if (IorDOutput !== 16'd20) begin
            failures++; $display("FAIL ld_memrd_addr actual=%h required=%h", IorDOutput, 16'd20);
        end
        MemDataOut = 16'hBEEF;
        issue("ld4", enc(5'b00011, 11'd4), 2, 16'hBEEF, 16'd178);
        e = sb.pop_front();
        checks++;
        if (dut.cr !== e.cr) begin
            failures++; $display("FAIL %s_cr actual=%h required=%h", e.name, dut.cr, e.cr);
        end
        checks++;
        if (IorDOutput !== e.pc) begin
            failures++; $display("FAIL %s_pc actual=%h required=%h", e.name, IorDOutput, e.pc);
        end
        // Second load interrupted by reset while in the memory-read state.
        repeat (3) @(negedge CLK);
        checks++;
        if (IorDOutput !== 16'hBEF3) begin
            failures++; $display("FAIL ld2_memrd_addr actual=%h required=%h", IorDOutput, 16'hBEF3);
        end
        MemDataOut = 16'h1234;
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        checks++;
        if (dut.cr !== 16'h0000) begin
            failures++; $display("FAIL rst_memrd_cr actual=%h required=%h", dut.cr, 16'h0000);
        end
        checks++;
        if (IorDOutput !== 16'h0000) begin
            failures++; $display("FAIL rst_memrd_pc actual=%h required=%h", IorDOutput, 16'h0000);
        end
        issue("addi1", enc(5'b01011, 11'd1), 4, 16'd1, 16'd1);
        e = sb.pop_front();
        checks++;
        if (dut.cr !== e.cr) begin
            failures++; $display("FAIL %s_cr actual=%h required=%h", e.name, dut.cr, e.cr);
        end
        checks++;
        if (IorDOutput !== e.pc) begin
            failures++; $display("FAIL %s_pc actual=%h required=%h", e.name, IorDOutput, e.pc);
        end
    endtask

    task automatic test_input();
        exp_t e;
        Input = 16'd9;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) issue("mov3", enc(5'b00000, 11'd3), 3, 16'd3, 16'd2);
            else begin
`ifdef IO_INPUT_EN
                issue("in", enc(5'b00100, 11'd0), 3, 16'd9, 16'd3);
`else
                issue("in_nop", enc(5'b00100, 11'd0), 2, 16'd3, 16'd3);
`endif
            end
            e = sb.pop_front();
            checks++;
            if (dut.cr !== e.cr) begin
                failures++; $display("FAIL %s_cr actual=%h required=%h", e.name, dut.cr, e.cr);
            end
            checks++;
            if (IorDOutput !== e.pc) begin
                failures++; $display("FAIL %s_pc actual=%h required=%h", e.name, IorDOutput, e.pc);
            end
        end
    endtask

    initial begin
        Reset       = 1'b1;
        Instruction = 16'h0000;
        MemDataOut  = 16'h0000;
        Input       = 16'h0000;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_jump();
        test_branch();
        test_alu_bounds();
        test_load_and_reset();
        test_input();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain actual=%0d required=%0d", sb.size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
